// File: rtl/cfu_if_pkg.sv
`timescale 1ns/1ps
// cfu_if_pkg: shared widths, payload structs and FSM states for the CFU
// cmd/rsp initiator.
//   FUNCT_ID_W - {funct7,funct3} width carried with every command/result
//   DATA_W     - operand / result word width
//   cmd_t      - one queued command (function id, two operands, expect_rsp)
//   res_t      - one queued result (function id of originating command, data)
//   state_e    - initiator FSM states
package cfu_if_pkg;

  localparam int FUNCT_ID_W = 10;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [FUNCT_ID_W-1:0] fid;
    logic [DATA_W-1:0]     in0;
    logic [DATA_W-1:0]     in1;
    logic                  expect_rsp;
  } cmd_t;

  typedef struct packed {
    logic [FUNCT_ID_W-1:0] fid;
    logic [DATA_W-1:0]     data;
  } res_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, reset   - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  - write request; ignored while full
//   pop          - consume head entry; ignored while empty
//   rdata        - head entry, valid whenever !empty
//   full, empty  - occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers/count, and a reset-free array maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cfu_cmd_initiator.sv
`timescale 1ns/1ps
// cfu_cmd_initiator: initiator end of the CFU cmd/rsp handshake.
// Host requests are queued in a command FIFO, issued one at a time to a CFU
// responder, and responses are collected into a result FIFO tagged with the
// originating function id. At most one command is outstanding.
//   clk, reset              - clock, synchronous active-high reset
//   req_*                   - host request port (valid/ready + payload)
//   cmd_*                   - CFU command port (valid/ready + payload)
//   rsp_*                   - CFU response port (valid/ready + payload)
//   res_*                   - result port (valid/ready + data, function id)
//   busy                    - FSM not idle or commands still queued
//   timeout_err, clear_err  - sticky response-timeout flag and its clear
//   issued_count            - command handshakes, wraps
//   dropped_count           - stray/late responses drained, saturates
module cfu_cmd_initiator
  import cfu_if_pkg::*;
#(
  parameter int          CMD_DEPTH      = 4,
  parameter int          RSP_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FUNCT_ID_W-1:0] req_function_id,
  input  logic [DATA_W-1:0]     req_inputs_0,
  input  logic [DATA_W-1:0]     req_inputs_1,
  input  logic                  req_expect_rsp,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [FUNCT_ID_W-1:0] cmd_payload_function_id,
  output logic [DATA_W-1:0]     cmd_payload_inputs_0,
  output logic [DATA_W-1:0]     cmd_payload_inputs_1,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_W-1:0]     rsp_payload_outputs_0,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic [FUNCT_ID_W-1:0] res_function_id,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  clear_err,
  output logic [15:0]           issued_count,
  output logic [7:0]            dropped_count
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    TIMER_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e                state, state_nxt;
  logic [TIMER_W-1:0]    timer;
  logic [FUNCT_ID_W-1:0] pending_fid;

  cmd_t cmd_wdata, cmd_head;
  res_t res_wdata, res_head;
  logic cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic res_push, res_full, res_empty;
  logic rsp_drop, timeout_hit;

  assign req_ready = !cmd_full;
  assign cmd_push  = req_valid && req_ready;
  assign cmd_wdata = '{fid: req_function_id, in0: req_inputs_0,
                       in1: req_inputs_1, expect_rsp: req_expect_rsp};
  // The command is already popped while its response is awaited, so its
  // function id comes from the copy taken at issue time.
  assign res_wdata = '{fid: pending_fid, data: rsp_payload_outputs_0};

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_push),
    .wdata (cmd_wdata),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RSP_DEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (res_push),
    .wdata (res_wdata),
    .pop   (res_ready),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty)
  );

  // Payloads are forced to zero while not valid so nothing stale or
  // uninitialised from the FIFO storage is ever visible on the ports.
  assign cmd_payload_function_id = cmd_valid ? cmd_head.fid : '0;
  assign cmd_payload_inputs_0    = cmd_valid ? cmd_head.in0 : '0;
  assign cmd_payload_inputs_1    = cmd_valid ? cmd_head.in1 : '0;
  assign res_valid               = !res_empty;
  assign res_data                = res_valid ? res_head.data : '0;
  assign res_function_id         = res_valid ? res_head.fid : '0;
  assign busy                    = (state != IDLE) || !cmd_empty;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    cmd_valid   = 1'b0;
    cmd_pop     = 1'b0;
    rsp_ready   = 1'b0;
    res_push    = 1'b0;
    rsp_drop    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        // Drain stray responses: a responder stuck on rsp_valid would
        // otherwise hold cmd_ready low forever.
        rsp_ready = rsp_valid;
        rsp_drop  = rsp_valid;
        // Only issue a response-bearing command when its result has a slot,
        // which is what keeps the result FIFO from ever overflowing.
        if (!cmd_empty && (!cmd_head.expect_rsp || !res_full)) state_nxt = ISSUE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        rsp_ready = rsp_valid;
        rsp_drop  = rsp_valid;
        if (cmd_ready) begin
          cmd_pop   = 1'b1;
          state_nxt = cmd_head.expect_rsp ? WAIT_RSP : IDLE;
        end
      end
      WAIT_RSP: begin
        rsp_ready = 1'b1;
        if (rsp_valid) begin
          res_push  = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      pending_fid   <= '0;
      timeout_err   <= 1'b0;
      issued_count  <= '0;
      dropped_count <= '0;
    end else begin
      state <= state_nxt;
      if ((state == WAIT_RSP) && !res_push && !timeout_hit) timer <= timer + 1'b1;
      else                                                  timer <= '0;
      if (cmd_pop) begin
        pending_fid  <= cmd_head.fid;
        issued_count <= issued_count + 16'd1;
      end
      // A timeout in the same cycle as clear_err leaves the flag set.
      if (timeout_hit)    timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
      if (rsp_drop && (dropped_count != 8'hFF)) dropped_count <= dropped_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
`timescale 1ns/1ps
// Directed bench for cfu_cmd_initiator. Inputs are driven and outputs
// checked at the falling clock edge; a small CFU responder model answers
// response-bearing commands one cycle after the command handshake with
// in0 + in1.
module tb_cfu_cmd_initiator;
  import cfu_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [9:0]  req_function_id;
  logic [31:0] req_inputs_0, req_inputs_1;
  logic        req_expect_rsp;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [9:0]  res_function_id;
  logic        busy, timeout_err, clear_err;
  logic [15:0] issued_count;
  logic [7:0]  dropped_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Test -> responder: expect_rsp of each accepted request, in order.
  bit exp_arr [64];
  int exp_wr = 0;
  bit responder_on = 1'b1;
  int inject_cnt = 0;

  // Responder-owned bookkeeping.
  int exp_rd = 0;
  int inject_done = 0;
  int hs_cyc [64];
  int hs_n = 0;
  bit cmd_hs, cmd_hs_exp, rsp_hs;
  logic [31:0] pend_data;

  cfu_cmd_initiator #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_function_id         (req_function_id),
    .req_inputs_0            (req_inputs_0),
    .req_inputs_1            (req_inputs_1),
    .req_expect_rsp          (req_expect_rsp),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .res_function_id         (res_function_id),
    .busy                    (busy),
    .timeout_err             (timeout_err),
    .clear_err               (clear_err),
    .issued_count            (issued_count),
    .dropped_count           (dropped_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Responder: at negedge+1 apply the effect of the previous rising edge,
  // at negedge+2 record which handshakes the next rising edge will make.
  initial begin
    rsp_valid = 1'b0;
    rsp_payload_outputs_0 = '0;
    cmd_hs = 1'b0;
    cmd_hs_exp = 1'b0;
    rsp_hs = 1'b0;
    pend_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_hs) rsp_valid = 1'b0;
      if (inject_cnt != inject_done) begin
        inject_done++;
        rsp_valid = 1'b1;
        rsp_payload_outputs_0 = 32'h0BAD_0BAD;
      end else if (cmd_hs && cmd_hs_exp && responder_on) begin
        rsp_valid = 1'b1;
        rsp_payload_outputs_0 = pend_data;
      end
      #1;
      rsp_hs = rsp_valid && rsp_ready;
      cmd_hs = cmd_valid && cmd_ready;
      cmd_hs_exp = 1'b0;
      if (cmd_hs) begin
        hs_cyc[hs_n] = cyc;
        hs_n++;
        cmd_hs_exp = exp_arr[exp_rd];
        exp_rd++;
        pend_data = cmd_payload_inputs_0 + cmd_payload_inputs_1;
      end
    end
  end

  // Starts at a falling edge; returns at the falling edge after acceptance.
  task automatic send_req(input logic [9:0] fid, input logic [31:0] a,
                          input logic [31:0] b, input logic e);
    int n = 0;
    req_valid = 1'b1;
    req_function_id = fid;
    req_inputs_0 = a;
    req_inputs_1 = b;
    req_expect_rsp = e;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_accept fid=%h: req_ready=%b after %0d cycles, required 1", fid, req_ready, n);
    end
    exp_arr[exp_wr] = e;
    exp_wr++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++;
    if ({cmd_valid, rsp_ready, res_valid, busy, timeout_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: cmd_valid/rsp_ready/res_valid/busy/timeout_err=%b want 00000",
               {cmd_valid, rsp_ready, res_valid, busy, timeout_err});
    end
    total++;
    if ({issued_count, dropped_count} !== 24'h0) begin
      bad++;
      $display("FAIL reset_counters: issued=%0d dropped=%0d want 0 0", issued_count, dropped_count);
    end
    total++;
    if ({cmd_payload_function_id, res_data, res_function_id} !== 52'h0) begin
      bad++;
      $display("FAIL reset_payload: cmd_fid=%h res_data=%h res_fid=%h want 0", cmd_payload_function_id, res_data, res_function_id);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    send_req(10'h008, 32'd5, 32'd7, 1'b1);
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL single_lat_n1: cmd_valid=%b want 0", cmd_valid); end
    @(negedge clk);
    total++;
    if ({cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !== {1'b1, 10'h008, 32'd5, 32'd7}) begin
      bad++;
      $display("FAIL single_cmd_n2: valid=%b fid=%h in0=%h in1=%h want 1 008 5 7",
               cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1);
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL single_res_early: res_valid=%b want 0", res_valid); end
    @(negedge clk);
    total++;
    if ({res_valid, res_data, res_function_id} !== {1'b1, 32'h0000000C, 10'h008}) begin
      bad++;
      $display("FAIL single_res: valid=%b data=%h fid=%h want 1 0000000c 008", res_valid, res_data, res_function_id);
    end
    total++;
    if (issued_count !== 16'd1) begin bad++; $display("FAIL single_issued: %0d want 1", issued_count); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if ({res_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_pop: res_valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int h0 = hs_n;
    bit seen = 1'b0;
    send_req(10'h040, 32'd1, 32'd1, 1'b0);
    send_req(10'h041, 32'd2, 32'd2, 1'b0);
    repeat (10) begin
      @(negedge clk);
      #3;
      if (res_valid || rsp_ready) seen = 1'b1;
    end
    @(negedge clk);
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL b2b_no_rsp: res_valid/rsp_ready seen high=%b want 0", seen); end
    total++;
    if (hs_n - h0 !== 2) begin
      bad++;
      $display("FAIL b2b_count: handshakes=%0d want 2", hs_n - h0);
    end else begin
      total++;
      if (hs_cyc[h0+1] - hs_cyc[h0] !== 2) begin
        bad++;
        $display("FAIL b2b_spacing: %0d cycles want 2", hs_cyc[h0+1] - hs_cyc[h0]);
      end
    end
    total++;
    if (issued_count !== 16'd3) begin bad++; $display("FAIL b2b_issued: %0d want 3", issued_count); end
  endtask

  task automatic test_result_full();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_req(10'(10'h010 + i), 32'(i + 1), 32'((i + 1) * 16), 1'b1);
    repeat (40) @(negedge clk);
    total++;
    if (issued_count !== 16'd7) begin bad++; $display("FAIL full_issued: %0d want 7", issued_count); end
    total++;
    if ({cmd_valid, busy, res_valid} !== 3'b011) begin
      bad++;
      $display("FAIL full_gate: cmd_valid=%b busy=%b res_valid=%b want 0 1 1", cmd_valid, busy, res_valid);
    end
    total++;
    if ({res_function_id, res_data} !== {10'h010, 32'd17}) begin
      bad++;
      $display("FAIL full_head: fid=%h data=%0d want 010 17", res_function_id, res_data);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (issued_count !== 16'd8) begin bad++; $display("FAIL full_release: issued=%0d want 8", issued_count); end
    for (int k = 1; k < 5; k++) begin
      total++;
      if ({res_valid, res_function_id, res_data} !== {1'b1, 10'(10'h010 + k), 32'((k + 1) * 17)}) begin
        bad++;
        $display("FAIL full_drain_%0d: valid=%b fid=%h data=%0d want 1 %h %0d",
                 k, res_valid, res_function_id, res_data, 10'(10'h010 + k), (k + 1) * 17);
      end
      res_ready = 1'b1;
      @(negedge clk);
    end
    res_ready = 1'b0;
    total++;
    if ({res_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL full_empty: res_valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_cmd_stall();
    cmd_ready = 1'b0;
    send_req(10'h155, 32'hDEADBEEF, 32'h12345678, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !==
          {1'b1, 10'h155, 32'hDEADBEEF, 32'h12345678}) begin
        bad++;
        $display("FAIL stall_hold_%0d: valid=%b fid=%h in0=%h in1=%h want 1 155 deadbeef 12345678",
                 i, cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1);
      end
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({cmd_valid, issued_count} !== {1'b0, 16'd9}) begin
      bad++;
      $display("FAIL stall_release: cmd_valid=%b issued=%0d want 0 9", cmd_valid, issued_count);
    end
  endtask

  task automatic test_timeout();
    responder_on = 1'b0;
    send_req(10'h020, 32'd1, 32'd2, 1'b1);
    repeat (17) @(negedge clk);
    total++;
    if ({timeout_err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL to_before: timeout_err=%b busy=%b want 0 1 in 16th wait cycle", timeout_err, busy);
    end
    @(negedge clk);
    total++;
    if ({timeout_err, busy, res_valid} !== 3'b100) begin
      bad++;
      $display("FAIL to_fire: timeout_err=%b busy=%b res_valid=%b want 1 0 0", timeout_err, busy, res_valid);
    end
    inject_cnt++;
    @(negedge clk);
    total++;
    if ({dropped_count, res_valid} !== {8'd1, 1'b0}) begin
      bad++;
      $display("FAIL to_drain: dropped=%0d res_valid=%b want 1 0", dropped_count, res_valid);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: timeout_err=%b want 0", timeout_err); end
    send_req(10'h021, 32'd3, 32'd4, 1'b1);
    repeat (17) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    total++;
    if ({timeout_err, issued_count} !== {1'b1, 16'd11}) begin
      bad++;
      $display("FAIL to_set_wins: timeout_err=%b issued=%0d want 1 11", timeout_err, issued_count);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear2: timeout_err=%b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    responder_on = 1'b0;
    send_req(10'h030, 32'd1, 32'd1, 1'b1);
    send_req(10'h031, 32'd2, 32'd2, 1'b1);
    send_req(10'h032, 32'd3, 32'd3, 1'b1);
    total++;
    if ({busy, cmd_valid, issued_count} !== {1'b1, 1'b0, 16'd12}) begin
      bad++;
      $display("FAIL mid_pre: busy=%b cmd_valid=%b issued=%0d want 1 0 12", busy, cmd_valid, issued_count);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({cmd_valid, res_valid, busy, req_ready, rsp_ready, timeout_err} !== 6'b000100) begin
      bad++;
      $display("FAIL mid_reset_flags: cmd_valid/res_valid/busy/req_ready/rsp_ready/timeout_err=%b want 000100",
               {cmd_valid, res_valid, busy, req_ready, rsp_ready, timeout_err});
    end
    total++;
    if ({issued_count, dropped_count} !== 24'h0) begin
      bad++;
      $display("FAIL mid_reset_counters: issued=%0d dropped=%0d want 0 0", issued_count, dropped_count);
    end
    repeat (5) @(negedge clk);
    total++;
    if ({cmd_valid, busy, issued_count} !== {1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL mid_abandoned: cmd_valid=%b busy=%b issued=%0d want 0 0 0", cmd_valid, busy, issued_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_function_id = '0;
    req_inputs_0 = '0;
    req_inputs_1 = '0;
    req_expect_rsp = 1'b0;
    cmd_ready = 1'b1;
    res_ready = 1'b0;
    clear_err = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_result_full();
    test_cmd_stall();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
